// File: rtl/mau_pkg.sv
// Shared types and constants for the MEM-stage access unit.
package mau_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StWrite,
        StRead,
        StResp
    } mau_state_t;

    localparam logic [15:0] MEM_REGION_MAX   = 16'h0002;
    localparam logic [31:0] REGION0_BASE     = 32'h0000_0000;
    localparam logic [31:0] REGION1_BASE     = 32'h0001_0000;
    localparam logic [31:0] REGION2_BASE     = 32'h0002_0000;
    localparam int unsigned DEFAULT_READ_LAT = 2;

    // Upper half of a word address selects the region; anything above the last one faults.
    function automatic logic addr_faults(input logic [31:0] addr);
        return addr[31:16] > MEM_REGION_MAX;
    endfunction

endpackage

// File: rtl/mem_access_unit_if.sv
// Pipeline request/response and data-memory-manager signals of the access unit.
// Signal suffixes are from the unit's point of view (slave modport).
interface mem_access_unit_if #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32
);
    logic              req_valid_i;
    logic              req_ready_o;
    logic              req_we_i;
    logic [ADDR_W-1:0] req_addr_i;
    logic [DATA_W-1:0] req_wdata_i;
    logic              resp_valid_o;
    logic [DATA_W-1:0] resp_rdata_o;
    logic              resp_err_o;
    logic [ADDR_W-1:0] mem_address_o;
    logic [DATA_W-1:0] mem_data_o;
    logic              mem_wren_o;
    logic [DATA_W-1:0] mem_data_i;

    modport slave (
        input  req_valid_i, req_we_i, req_addr_i, req_wdata_i, mem_data_i,
        output req_ready_o, resp_valid_o, resp_rdata_o, resp_err_o,
        output mem_address_o, mem_data_o, mem_wren_o
    );

    modport master (
        output req_valid_i, req_we_i, req_addr_i, req_wdata_i, mem_data_i,
        input  req_ready_o, resp_valid_o, resp_rdata_o, resp_err_o,
        input  mem_address_o, mem_data_o, mem_wren_o
    );
endinterface

// File: rtl/mem_access_unit.sv
// MEM-stage front end: one load/store at a time into the data memory manager.
// Optional address range fault checking is enabled by defining MAU_RANGE_CHECK_EN.
module mem_access_unit
    import mau_pkg::*;
#(
    parameter int unsigned ADDR_W   = 32,
    parameter int unsigned DATA_W   = 32,
    parameter int unsigned READ_LAT = DEFAULT_READ_LAT
) (
    input logic             CLK,
    input logic             RST,
    mem_access_unit_if.slave bus
);

    mau_state_t        r_state;
    mau_state_t        w_state_next;
    logic              r_we;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_wdata;
    logic [DATA_W-1:0] r_rdata;
    logic [2:0]        r_lat_cnt;
    logic              w_accept;
    logic              w_last_beat;
    logic              w_fault;
    logic              w_err;

    assign w_accept    = bus.req_valid_i && (r_state == StIdle);
    assign w_last_beat = (r_lat_cnt == 3'(READ_LAT - 1));

`ifdef MAU_RANGE_CHECK_EN
    logic r_err;

    assign w_fault = addr_faults(bus.req_addr_i);
    assign w_err   = r_err;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_err <= 1'b0;
        end else if (w_accept) begin
            r_err <= w_fault;
        end
    end
`else
    assign w_fault = 1'b0;
    assign w_err   = 1'b0;
`endif

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            StIdle: begin
                if (w_accept) begin
                    if (w_fault) begin
                        w_state_next = StResp;
                    end else if (bus.req_we_i) begin
                        w_state_next = StWrite;
                    end else begin
                        w_state_next = StRead;
                    end
                end
            end
            StWrite: w_state_next = StIdle;
            StRead:  if (w_last_beat) w_state_next = StResp;
            StResp:  w_state_next = StIdle;
            default: w_state_next = StIdle;
        endcase
    end

    // Latches are only reloaded on accept, so the manager sees a stable address throughout.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_we      <= 1'b0;
            r_addr    <= '0;
            r_wdata   <= '0;
            r_rdata   <= '0;
            r_lat_cnt <= '0;
        end else begin
            if (w_accept) begin
                r_we      <= bus.req_we_i;
                r_addr    <= bus.req_addr_i;
                r_wdata   <= bus.req_wdata_i;
                r_lat_cnt <= '0;
            end
            if (r_state == StRead) begin
                r_lat_cnt <= r_lat_cnt + 3'd1;
                if (w_last_beat) begin
                    r_rdata <= bus.mem_data_i;
                end
            end
        end
    end

    assign bus.req_ready_o   = (r_state == StIdle);
    assign bus.mem_wren_o    = (r_state == StWrite) && r_we;
    assign bus.mem_address_o = r_addr;
    assign bus.mem_data_o    = r_wdata;
    assign bus.resp_valid_o  = (r_state == StWrite) || (r_state == StResp);
    assign bus.resp_rdata_o  = ((r_state == StResp) && !w_err) ? r_rdata : '0;
    assign bus.resp_err_o    = (r_state == StResp) && w_err;

endmodule
